// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: access-size encodings and arbiter FSM states.
// Used by the arbiter, its legality checker and the data memory model.
package dmem_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_BYTE = 3'b001;
    localparam logic [2:0] OP_HALF = 3'b010;
    localparam logic [2:0] OP_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Access size in bytes; zero flags an unknown encoding.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OP_BYTE: return 3'd1;
            OP_HALF: return 3'd2;
            OP_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Flags an access as illegal: unknown size, misaligned, or running past ADDR_LIMIT.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int ADDR_LIMIT = 32
) (
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        err
);

    logic [2:0]  size;
    logic [32:0] end_addr;

    // The sum is widened to 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        size     = op_size(op);
        end_addr = {1'b0, addr} + {30'b0, size};
        err      = 1'b0;
        if (size == 3'd0) begin
            err = 1'b1;
        end else if (op == OP_HALF && addr[0] != 1'b0) begin
            err = 1'b1;
        end else if (op == OP_WORD && addr[1:0] != 2'b00) begin
            err = 1'b1;
        end
        if (end_addr > 33'(ADDR_LIMIT)) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one access per two cycles with registered responses.
// Define DMEM_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_LIMIT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic        chk_err, grant_any, in_access;
    logic [31:0] read_data, resp_data;
`ifdef DMEM_ARB_RR_EN
    logic        prio_q, prio_d;
`endif

    dmem_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_check (
        .op   (op_q),
        .addr (addr_q),
        .err  (chk_err)
    );

    assign in_access = (state_q == ST_ACCESS) && !reset;

    // prio_q names the requester that wins the next tie; it flips away from each grantee.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && state_q != ST_ACCESS) begin
            if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                gnt0 = !prio_q;
                gnt1 = prio_q;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
        grant_any = gnt0 | gnt1;
`ifdef DMEM_ARB_RR_EN
        prio_d = prio_q;
        if (grant_any) begin
            prio_d = gnt0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE:   state_d = grant_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = grant_any ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (grant_any) begin
            owner_d = gnt1;
            we_d    = gnt1 ? we1    : we0;
            op_d    = gnt1 ? op1    : op0;
            addr_d  = gnt1 ? addr1  : addr0;
            wdata_d = gnt1 ? wdata1 : wdata0;
        end
    end

    // Memory answers big-endian: the addressed byte sits in mem_dout[31:24].
    always_comb begin
        case (op_q)
            OP_BYTE: read_data = {24'h0, mem_dout[31:24]};
            OP_HALF: read_data = {16'h0, mem_dout[31:16]};
            OP_WORD: read_data = mem_dout;
            default: read_data = 32'h0;
        endcase
        resp_data = (we_q || chk_err) ? 32'h0 : read_data;
        rvalid0_d = in_access && !owner_q;
        rvalid1_d = in_access && owner_q;
        rdata0_d  = rvalid0_d ? resp_data : 32'h0;
        rdata1_d  = rvalid1_d ? resp_data : 32'h0;
        err0_d    = rvalid0_d && chk_err;
        err1_d    = rvalid1_d && chk_err;
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_op   = OP_NOP;
        mem_addr = 32'h0;
        mem_din  = 32'h0;
        if (in_access) begin
            mem_addr = addr_q;
            mem_din  = wdata_q;
            if (!chk_err) begin
                mem_we = we_q;
                mem_op = op_q;
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            op_q      <= OP_NOP;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            prio_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
`ifdef DMEM_ARB_RR_EN
            prio_q    <= prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level model with a big-endian memory.
// Honours DMEM_ARB_RR_EN when choosing expected tie-break order.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int ADDR_LIMIT = 32;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    typedef struct packed {
        logic        rq;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    localparam rq_t NONE = '0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  op0 = 3'b0, op1 = 3'b0;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_addr, mem_din;
    logic [31:0] mem_dout = 32'h0;
    logic [2:0]  mem_op;

    logic [7:0]  mem_arr [0:63];
    logic [7:0]  ref_mem [0:63];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    // Data memory: acts on the falling edge, big-endian, write data right-justified.
    always @(negedge clk) begin
        logic [5:0] a;
        a = mem_addr[5:0];
        if (mem_op != OP_NOP) begin
            if (mem_we) begin
                case (mem_op)
                    OP_BYTE: mem_arr[a] <= mem_din[7:0];
                    OP_HALF: begin
                        mem_arr[a] <= mem_din[15:8];
                        mem_arr[a + 6'd1] <= mem_din[7:0];
                    end
                    default: begin
                        mem_arr[a] <= mem_din[31:24];
                        mem_arr[a + 6'd1] <= mem_din[23:16];
                        mem_arr[a + 6'd2] <= mem_din[15:8];
                        mem_arr[a + 6'd3] <= mem_din[7:0];
                    end
                endcase
            end else begin
                mem_dout <= {mem_arr[a], mem_arr[a + 6'd1], mem_arr[a + 6'd2], mem_arr[a + 6'd3]};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [2:0] op, input logic [31:0] addr);
        longint unsigned size;
        longint unsigned a;
        a = addr;
        case (op)
            3'b001:  size = 1;
            3'b010:  size = 2;
            3'b100:  size = 4;
            default: return 1'b1;
        endcase
        if (a % size != 0) return 1'b1;
        return (a + size > ADDR_LIMIT);
    endfunction

    function automatic logic [31:0] ref_read(input logic [2:0] op, input logic [31:0] addr);
        int a;
        a = int'(addr[4:0]);
        case (op)
            3'b001:  return {24'h0, ref_mem[a]};
            3'b010:  return {16'h0, ref_mem[a], ref_mem[a+1]};
            default: return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
        endcase
    endfunction

    task automatic ref_write(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        int a;
        a = int'(addr[4:0]);
        case (op)
            3'b001: ref_mem[a] = d[7:0];
            3'b010: begin ref_mem[a] = d[15:8]; ref_mem[a+1] = d[7:0]; end
            default: begin
                ref_mem[a] = d[31:24]; ref_mem[a+1] = d[23:16];
                ref_mem[a+2] = d[15:8]; ref_mem[a+3] = d[7:0];
            end
        endcase
    endtask

    // Model: a grant in cycle c occupies the memory in c+1 and answers in c+2.
    initial begin : compare_proc
        txn_t acc, resp;
        bit   acc_valid, resp_valid;
        logic e_g0, e_g1, e_mwe;
        logic [2:0] e_mop;
        logic [31:0] e_maddr, e_mdin;
`ifdef DMEM_ARB_RR_EN
        bit   tie_pref;
        tie_pref = 1'b0;
`endif
        acc = '0; resp = '0; acc_valid = 1'b0; resp_valid = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (!reset && !acc_valid) begin
                if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
                    if (tie_pref) e_g1 = 1'b1; else e_g0 = 1'b1;
`else
                    e_g0 = 1'b1;
`endif
                end else begin
                    e_g0 = req0;
                    e_g1 = req1;
                end
            end
            e_mwe = 1'b0; e_mop = OP_NOP; e_maddr = 32'h0; e_mdin = 32'h0;
            if (acc_valid) begin
                acc.err   = is_illegal(acc.op, acc.addr);
                acc.rdata = (acc.err || acc.we) ? 32'h0 : ref_read(acc.op, acc.addr);
                if (!reset) begin
                    e_maddr = acc.addr;
                    e_mdin  = acc.wdata;
                    if (!acc.err) begin
                        e_mop = acc.op;
                        e_mwe = acc.we;
                        if (acc.we) ref_write(acc.op, acc.addr, acc.wdata);
                    end
                end
            end
            checkOutput("gnt0", gnt0, e_g0);
            checkOutput("gnt1", gnt1, e_g1);
            checkOutput("mem_we", mem_we, e_mwe);
            checkOutput("mem_op", mem_op, e_mop);
            checkOutput("mem_addr", mem_addr, e_maddr);
            checkOutput("mem_din", mem_din, e_mdin);
            checkOutput("rvalid0", rvalid0, resp_valid && !resp.rq);
            checkOutput("rvalid1", rvalid1, resp_valid && resp.rq);
            checkOutput("rdata0", rdata0, (resp_valid && !resp.rq) ? resp.rdata : 32'h0);
            checkOutput("rdata1", rdata1, (resp_valid && resp.rq) ? resp.rdata : 32'h0);
            checkOutput("err0", err0, resp_valid && !resp.rq && resp.err);
            checkOutput("err1", err1, resp_valid && resp.rq && resp.err);
            checkOutput("busy", busy, acc_valid || resp_valid);
            resp_valid = acc_valid && !reset;
            resp       = acc;
            acc_valid  = e_g0 || e_g1;
            if (e_g1)      acc = '{1'b1, we1, op1, addr1, wdata1, 1'b0, 32'h0};
            else if (e_g0) acc = '{1'b0, we0, op0, addr0, wdata0, 1'b0, 32'h0};
`ifdef DMEM_ARB_RR_EN
            if (reset)     tie_pref = 1'b0;
            else if (e_g0) tie_pref = 1'b1;
            else if (e_g1) tie_pref = 1'b0;
`endif
        end
    end

    function automatic rq_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata);
        return '{1'b1, we, op, addr, wdata};
    endfunction

    function automatic rq_t randRq();
        rq_t s;
        int  r;
        s.req   = 1'($urandom_range(0, 1));
        s.we    = 1'($urandom_range(0, 1));
        r       = int'($urandom_range(0, 7));
        s.op    = (r < 2) ? OP_BYTE : (r < 4) ? OP_HALF : (r < 6) ? OP_WORD : 3'($urandom);
        s.addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 35));
        s.wdata = $urandom;
        return s;
    endfunction

    task automatic applyStimulus(input rq_t s0, input rq_t s1, input logic rst);
        @(posedge clk);
        #1;
        reset = rst;
        req0 = s0.req; we0 = s0.we; op0 = s0.op; addr0 = s0.addr; wdata0 = s0.wdata;
        req1 = s1.req; we1 = s1.we; op1 = s1.op; addr1 = s1.addr; wdata1 = s1.wdata;
    endtask

    // Issues one access, then samples the memory port and the response two cycles later.
    task automatic doAccess(input logic rq, input rq_t s, output logic mwe, output logic [2:0] mop,
                            output logic [31:0] maddr, output logic [31:0] mdin,
                            output logic rv, output logic [31:0] rd, output logic er);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            applyStimulus(rq ? NONE : s, rq ? s : NONE, 1'b0);
            @(negedge clk);
            #2;
            got = rq ? gnt1 : gnt0;
            n++;
        end
        if (!got) checkOutput("grant timeout", 32'd0, 32'd1);
        applyStimulus(NONE, NONE, 1'b0);
        @(negedge clk);
        #2;
        mwe = mem_we; mop = mem_op; maddr = mem_addr; mdin = mem_din;
        applyStimulus(NONE, NONE, 1'b0);
        @(negedge clk);
        #2;
        rv = rq ? rvalid1 : rvalid0;
        rd = rq ? rdata1 : rdata0;
        er = rq ? err1 : err0;
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        logic        mwe, rv, er;
        logic [2:0]  mop;
        logic [31:0] maddr, mdin, rd;
        int          winners[$];
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[4] = 8'h11; mem_arr[5] = 8'h22; mem_arr[6] = 8'h33; mem_arr[7] = 8'h44;
        for (int i = 4; i < 8; i++) ref_mem[i] = mem_arr[i];

        applyStimulus(mk(1'b0, OP_WORD, 32'd4, 32'h0), NONE, 1'b1);
        applyStimulus(mk(1'b0, OP_WORD, 32'd4, 32'h0), NONE, 1'b1);
        @(negedge clk);
        #2;
        checkOutput("reset gnt0", gnt0, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rvalid0", rvalid0, 0);
        checkOutput("reset rdata1", rdata1, 0);
        checkOutput("reset mem_op", mem_op, 0);
        checkOutput("reset mem_addr", mem_addr, 0);
        applyStimulus(NONE, NONE, 1'b0);

        doAccess(1'b0, mk(1'b0, OP_WORD, 32'd4, 32'h0), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("word rd mem_op", mop, OP_WORD);
        checkOutput("word rd rvalid0", rv, 1);
        checkOutput("word rd rdata0", rd, 32'h11223344);

        doAccess(1'b1, mk(1'b1, OP_BYTE, 32'd31, 32'hA5), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("byte wr mem_we", mwe, 1);
        checkOutput("byte wr mem_addr", maddr, 31);
        checkOutput("byte wr mem_din", mdin, 32'hA5);
        checkOutput("byte wr ack rdata1", rd, 0);
        doAccess(1'b1, mk(1'b0, OP_BYTE, 32'd31, 32'h0), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("byte rd rdata1", rd, 32'h000000A5);

        doAccess(1'b0, mk(1'b0, OP_WORD, 32'd30, 32'h0), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("word@30 mem_op", mop, 0);
        checkOutput("word@30 err0", er, 1);
        checkOutput("word@30 rdata0", rd, 0);
        doAccess(1'b0, mk(1'b0, OP_HALF, 32'd3, 32'h0), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("half@3 rvalid0", rv, 1);
        checkOutput("half@3 err0", er, 1);
        doAccess(1'b1, mk(1'b1, 3'b011, 32'd0, 32'h5), mwe, mop, maddr, mdin, rv, rd, er);
        checkOutput("op011 mem_op", mop, 0);
        checkOutput("op011 mem_we", mwe, 0);
        checkOutput("op011 err1", er, 1);

        applyStimulus(NONE, NONE, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(mk(1'b0, OP_WORD, 32'd0, 32'h0), mk(1'b0, OP_WORD, 32'd8, 32'h0), 1'b0);
            @(negedge clk);
            #2;
            if (gnt0) winners.push_back(0);
            else if (gnt1) winners.push_back(1);
        end
        checkOutput("contended grant count", 32'(winners.size()), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            checkOutput($sformatf("contended grant %0d", i), (i < winners.size()) ? 32'(winners[i]) : 32'd99, 32'(i % 2));
`else
            checkOutput($sformatf("contended grant %0d", i), (i < winners.size()) ? 32'(winners[i]) : 32'd99, 32'd0);
`endif
        end

        repeat (3) applyStimulus(NONE, NONE, 1'b0);
        applyStimulus(mk(1'b1, OP_WORD, 32'd8, 32'hDEADBEEF), NONE, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("rst-in-access gnt0", gnt0, 1);
        applyStimulus(NONE, NONE, 1'b1);
        @(negedge clk);
        #2;
        checkOutput("rst-in-access mem_we", mem_we, 0);
        applyStimulus(NONE, NONE, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("after rst rvalid0", rvalid0, 0);
        checkOutput("after rst busy", busy, 0);
        checkOutput("after rst mem_we", mem_we, 0);

        for (int cyc = 0; cyc < 800; cyc++) begin
            applyStimulus(randRq(), randRq(), $urandom_range(0, 49) == 0);
        end
        repeat (4) applyStimulus(NONE, NONE, 1'b0);
        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
